// File: rtl/regfile_read_port_if.sv
// Write-wordline / dual source-read bundle between decode and the register file.
// The master drives the write and the read request; the slave returns the registered read data.
interface regfile_read_port_if #(
  parameter int unsigned DATA_W = 16
);
  logic [15:0]       Wordline;
  logic [DATA_W-1:0] WriteData;
  logic              ReadEn;
  logic [3:0]        SrcReg1;
  logic [3:0]        SrcReg2;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;
  logic              RdValid;
  logic              WlErr;

  modport master (
    output Wordline, WriteData, ReadEn, SrcReg1, SrcReg2,
    input  SrcData1, SrcData2, RdValid, WlErr
  );

  modport slave (
    input  Wordline, WriteData, ReadEn, SrcReg1, SrcReg2,
    output SrcData1, SrcData2, RdValid, WlErr
  );
endinterface

// File: rtl/regfile_read_port.sv
// 16 x DATA_W architectural register file: one-hot wordline write port and
// two registered source-read ports with write-through bypass.
module regfile_read_port #(
  parameter int unsigned DATA_W   = 16,
  parameter int          NUM_REGS = 16,
  parameter bit          ZERO_R0  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  regfile_read_port_if.slave bus
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_valid;
  logic              r_wlerr;

  logic [15:0]       w_wl_eff;
  logic              w_multi;
  logic [15:0]       w_row1;
  logic [15:0]       w_row2;
  logic [DATA_W-1:0] w_mux1;
  logic [DATA_W-1:0] w_mux2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Row 0 drops out of both the write and the multi-hot count when it is hardwired.
  assign w_wl_eff = ZERO_R0 ? {bus.Wordline[15:1], 1'b0} : bus.Wordline;
  assign w_multi  = |(w_wl_eff & (w_wl_eff - 16'd1));

  always_comb begin
    w_row1 = 16'd1 << bus.SrcReg1;
    w_row2 = 16'd1 << bus.SrcReg2;
    w_mux1 = '0;
    w_mux2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_row1[i]) w_mux1 = w_mux1 | r_regs[i];
      if (w_row2[i]) w_mux2 = w_mux2 | r_regs[i];
    end
    w_rd1 = (|(w_row1 & w_wl_eff)) ? bus.WriteData : w_mux1;
    w_rd2 = (|(w_row2 & w_wl_eff)) ? bus.WriteData : w_mux2;
    if (ZERO_R0 && bus.SrcReg1 == 4'd0) w_rd1 = '0;
    if (ZERO_R0 && bus.SrcReg2 == 4'd0) w_rd2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_src1  <= '0;
      r_src2  <= '0;
      r_valid <= 1'b0;
      r_wlerr <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wl_eff[i]) r_regs[i] <= bus.WriteData;
      end
      if (bus.ReadEn) begin
        r_src1 <= w_rd1;
        r_src2 <= w_rd2;
      end
      r_valid <= bus.ReadEn;
      if (w_multi) r_wlerr <= 1'b1;
    end
  end

  assign bus.SrcData1 = r_src1;
  assign bus.SrcData2 = r_src2;
  assign bus.RdValid  = r_valid;
  assign bus.WlErr    = r_wlerr;

endmodule
